// File: rtl/pgm_ddr_pkg.sv
// rtl/pgm_ddr_pkg.sv - shared widths, FSM state and write-buffer entry for the DDR responder
package pgm_ddr_pkg;

    localparam int DDR_AW  = 29;
    localparam int DDR_DW  = 64;
    localparam int DDR_BEW = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RD_DONE
    } ddr_state_t;

    typedef struct packed {
        logic [DDR_AW-1:0]  addr;
        logic [DDR_DW-1:0]  din;
        logic [DDR_BEW-1:0] be;
    } wfifo_entry_t;

endpackage

// File: rtl/pgm_ddr_responder_if.sv
// rtl/pgm_ddr_responder_if.sv - core-side request/response and Avalon DDRAM signal bundle
interface pgm_ddr_responder_if;
    import pgm_ddr_pkg::*;

    logic                core_rd;
    logic                core_we;
    logic [DDR_AW-1:0]   core_addr;
    logic [DDR_DW-1:0]   core_din;
    logic [DDR_BEW-1:0]  core_be;
    logic [DDR_DW-1:0]   core_dout;
    logic                core_dout_ready;
    logic                core_busy;

    logic [7:0]          ddr_burstcnt;
    logic [DDR_AW-1:0]   ddr_addr;
    logic                ddr_rd;
    logic                ddr_we;
    logic [DDR_DW-1:0]   ddr_din;
    logic [DDR_BEW-1:0]  ddr_be;
    logic [DDR_DW-1:0]   ddr_dout;
    logic                ddr_dout_ready;
    logic                ddr_busy;

    modport slave (
        input  core_rd, core_we, core_addr, core_din, core_be,
        input  ddr_dout, ddr_dout_ready, ddr_busy,
        output core_dout, core_dout_ready, core_busy,
        output ddr_burstcnt, ddr_addr, ddr_rd, ddr_we, ddr_din, ddr_be
    );

    modport master (
        output core_rd, core_we, core_addr, core_din, core_be,
        output ddr_dout, ddr_dout_ready, ddr_busy,
        input  core_dout, core_dout_ready, core_busy,
        input  ddr_burstcnt, ddr_addr, ddr_rd, ddr_we, ddr_din, ddr_be
    );

endinterface

// File: rtl/pgm_ddr_wfifo.sv
// rtl/pgm_ddr_wfifo.sv - synchronous write buffer holding {addr,din,be} entries
module pgm_ddr_wfifo
    import pgm_ddr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   fixed_50m_clk,
    input  logic                   reset,
    input  logic                   push,
    input  wfifo_entry_t           push_data,
    input  logic                   pop,
    output wfifo_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    wfifo_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A push into a full buffer is only taken when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge fixed_50m_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge fixed_50m_clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pgm_ddr_responder.sv
// rtl/pgm_ddr_responder.sv - core read/write responder on a single-beat Avalon DDRAM port with write buffer and one-line read cache
module pgm_ddr_responder
    import pgm_ddr_pkg::*;
#(
    parameter int WFIFO_DEPTH = 4,
    parameter int CACHE_EN    = 1
) (
    input  logic                fixed_50m_clk,
    input  logic                reset,
    pgm_ddr_responder_if.slave  bus
);

    localparam int CW = $clog2(WFIFO_DEPTH) + 1;

    ddr_state_t         state;
    ddr_state_t         state_next;
    wfifo_entry_t       wf_in;
    wfifo_entry_t       wf_head;
    logic [CW-1:0]      wf_count;
    logic [CW-1:0]      count_next;
    logic               wf_full;
    logic               wf_empty;
    logic               push_ok;
    logic               pop;
    logic [DDR_AW-1:0]  rd_addr;
    logic [DDR_AW-1:0]  cache_tag;
    logic [DDR_DW-1:0]  cache_data;
    logic               cache_valid;
    logic               cache_hit;

    assign bus.ddr_burstcnt = 8'd1;
    assign wf_in      = '{addr: bus.core_addr, din: bus.core_din, be: bus.core_be};
    assign push_ok    = bus.core_we && (!wf_full || pop);
    assign count_next = wf_count + CW'(push_ok) - CW'(pop);
    assign cache_hit  = (CACHE_EN != 0) && cache_valid && (cache_tag == bus.core_addr);

    pgm_ddr_wfifo #(
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .fixed_50m_clk (fixed_50m_clk),
        .reset         (reset),
        .push          (push_ok),
        .push_data     (wf_in),
        .pop           (pop),
        .head          (wf_head),
        .count         (wf_count),
        .full          (wf_full),
        .empty         (wf_empty)
    );

    always_ff @(posedge fixed_50m_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Pending writes always drain before a read is looked at, keeping read-after-write order.
    always_comb begin
        state_next          = state;
        pop                 = 1'b0;
        bus.ddr_rd          = 1'b0;
        bus.ddr_we          = 1'b0;
        bus.ddr_addr        = '0;
        bus.ddr_din         = '0;
        bus.ddr_be          = '0;
        bus.core_dout_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!wf_empty)        state_next = WR;
                else if (bus.core_rd) state_next = cache_hit ? RD_DONE : RD_REQ;
            end
            WR: begin
                bus.ddr_we   = 1'b1;
                bus.ddr_addr = wf_head.addr;
                bus.ddr_din  = wf_head.din;
                bus.ddr_be   = wf_head.be;
                if (!bus.ddr_busy) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_REQ: begin
                bus.ddr_rd   = 1'b1;
                bus.ddr_addr = rd_addr;
                if (!bus.ddr_busy) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.ddr_dout_ready) state_next = RD_DONE;
            end
            RD_DONE: begin
                bus.core_dout_ready = 1'b1;
                state_next          = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge fixed_50m_clk or posedge reset) begin
        if (reset) begin
            rd_addr       <= '0;
            bus.core_dout <= '0;
            bus.core_busy <= 1'b0;
            cache_tag     <= '0;
            cache_data    <= '0;
            cache_valid   <= 1'b0;
        end else begin
            // Busy tracks the count the buffer will hold after this edge.
            bus.core_busy <= (count_next >= CW'(WFIFO_DEPTH - 1));
            if (state == IDLE && wf_empty && bus.core_rd) begin
                rd_addr <= bus.core_addr;
                if (cache_hit) bus.core_dout <= cache_data;
            end
            if (state == RD_WAIT && bus.ddr_dout_ready) begin
                bus.core_dout <= bus.ddr_dout;
                cache_data    <= bus.ddr_dout;
                cache_tag     <= rd_addr;
                cache_valid   <= (CACHE_EN != 0);
            end
            if (pop && wf_head.addr == cache_tag) cache_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pgm_ddr_responder.sv
// tb/tb_pgm_ddr_responder.sv - directed and random checks of pgm_ddr_responder against a DDR and memory model
module tb_pgm_ddr_responder;
    import pgm_ddr_pkg::*;

    logic fixed_50m_clk = 1'b0;
    logic reset;
    always #5 fixed_50m_clk = ~fixed_50m_clk;

    pgm_ddr_responder_if bus();

    pgm_ddr_responder #(
        .WFIFO_DEPTH (4),
        .CACHE_EN    (1)
    ) dut (
        .fixed_50m_clk (fixed_50m_clk),
        .reset         (reset),
        .bus           (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // DDR busy: forced level or per-cycle random
    logic busy_force = 1'b0;
    logic busy_rand  = 1'b0;
    logic rnd_busy   = 1'b0;
    assign bus.ddr_busy = busy_rand ? rnd_busy : busy_force;
    always @(posedge fixed_50m_clk) begin
        #1;
        rnd_busy = 1'($urandom_range(0, 1));
    end

    int cyc = 0;
    always @(posedge fixed_50m_clk) cyc++;

    logic [63:0] ddr_mem [logic [28:0]];
    logic [63:0] ref_mem [logic [28:0]];
    logic [28:0] wlog_addr [$];
    logic [63:0] wlog_data [$];

    function automatic logic [63:0] pat(input logic [28:0] a);
        return {16'hC0DE, 19'd0, a};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ddr_get(input logic [28:0] a);
        return ddr_mem.exists(a) ? ddr_mem[a] : pat(a);
    endfunction

    function automatic logic [63:0] ref_get(input logic [28:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    // DDR model: sampled at negedge, so a command seen here is accepted by the next rising edge.
    // A read accepted at edge A returns ddr_dout_ready sampled at edge A+rd_lat.
    int          rd_lat = 1;
    int          rd_pend = 0;
    logic [28:0] rd_paddr;
    int          rd_cycles = 0;
    int          n_resp = 0;
    int          excl_viol = 0;
    int          rd_accept_t = 0;
    int          wr_accept_t = 0;
    always @(negedge fixed_50m_clk) begin
        bus.ddr_dout_ready = 1'b0;
        if (rd_pend > 0) begin
            rd_pend--;
            if (rd_pend == 0) begin
                bus.ddr_dout_ready = 1'b1;
                bus.ddr_dout       = ddr_get(rd_paddr);
                n_resp++;
            end
        end
        if (bus.ddr_rd && bus.ddr_we) excl_viol++;
        if (bus.ddr_rd) rd_cycles++;
        if (bus.ddr_rd && !bus.ddr_busy) begin
            rd_pend     = rd_lat;
            rd_paddr    = bus.ddr_addr;
            rd_accept_t = cyc;
        end
        if (bus.ddr_we && !bus.ddr_busy) begin
            ddr_mem[bus.ddr_addr] = merge(ddr_get(bus.ddr_addr), bus.ddr_din, bus.ddr_be);
            wlog_addr.push_back(bus.ddr_addr);
            wlog_data.push_back(bus.ddr_din);
            wr_accept_t = cyc;
        end
    end

    // Latency counts the rising edge at which the core samples core_dout_ready, from the edge core_rd was raised after.
    task automatic do_read(input logic [28:0] a, output logic [63:0] d, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        d   = '0;
        @(posedge fixed_50m_clk); #1;
        bus.core_rd   = 1'b1;
        bus.core_addr = a;
        for (int k = 0; k < 120 && !ok; k++) begin
            @(negedge fixed_50m_clk);
            lat++;
            if (bus.core_dout_ready) begin
                d  = bus.core_dout;
                ok = 1'b1;
            end
        end
        @(posedge fixed_50m_clk); #1;
        bus.core_rd = 1'b0;
    endtask

    task automatic do_write(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
        int n = 0;
        @(posedge fixed_50m_clk); #1;
        while (bus.core_busy && n < 200) begin
            @(posedge fixed_50m_clk); #1;
            n++;
        end
        bus.core_we   = 1'b1;
        bus.core_addr = a;
        bus.core_din  = d;
        bus.core_be   = be;
        ref_mem[a]    = merge(ref_get(a), d, be);
        @(posedge fixed_50m_clk); #1;
        bus.core_we = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int          lat;
        bit          ok;
        int          r0;
        int          cnt;
        logic [5:0]  busy_hist;

        reset         = 1'b1;
        bus.core_rd   = 1'b0;
        bus.core_we   = 1'b0;
        bus.core_addr = '0;
        bus.core_din  = '0;
        bus.core_be   = '0;
        ddr_mem[29'h100] = 64'h1122334455667788;
        ref_mem[29'h100] = 64'h1122334455667788;

        repeat (3) @(posedge fixed_50m_clk);
        @(negedge fixed_50m_clk);
        check("rst_ctrl", {60'd0, bus.core_dout_ready, bus.core_busy, bus.ddr_rd, bus.ddr_we}, 64'd0);
        check("rst_core_dout", bus.core_dout, 64'd0);
        check("rst_ddr_addr", 64'(bus.ddr_addr), 64'd0);
        check("rst_ddr_din", bus.ddr_din, 64'd0);
        check("rst_ddr_be", 64'(bus.ddr_be), 64'd0);
        check("burstcnt", 64'(bus.ddr_burstcnt), 64'd1);
        @(posedge fixed_50m_clk); #1;
        reset = 1'b0;

        // First read of 0x100: miss, DDR answers 5 cycles after accepting
        rd_lat = 5;
        r0 = rd_cycles;
        do_read(29'h100, d, lat, ok);
        check("s1_ok", 64'(ok), 64'd1);
        check("s1_data", d, 64'h1122334455667788);
        check("s1_latency", 64'(lat), 64'd8);
        check("s1_ddr_rd_cycles", 64'(rd_cycles - r0), 64'd1);

        // Repeat read: served from the cache line
        r0 = rd_cycles;
        do_read(29'h100, d, lat, ok);
        check("s2_ok", 64'(ok), 64'd1);
        check("s2_data", d, 64'h1122334455667788);
        check("s2_latency", 64'(lat), 64'd2);
        check("s2_ddr_rd_cycles", 64'(rd_cycles - r0), 64'd0);

        // Six back-to-back strobes against a stalled DDR
        wlog_addr.delete();
        wlog_data.delete();
        @(posedge fixed_50m_clk); #1;
        busy_force = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.core_we   = 1'b1;
            bus.core_addr = 29'h200 + 29'(i);
            bus.core_din  = {32'hD00D0000, 32'(i)};
            bus.core_be   = 8'hFF;
            @(posedge fixed_50m_clk); #1;
            busy_hist[i] = bus.core_busy;
        end
        bus.core_we = 1'b0;
        check("s3_busy_history", 64'(busy_hist), 64'b111100);
        check("s3_we_held", 64'(bus.ddr_we), 64'd1);
        check("s3_head_addr", 64'(bus.ddr_addr), 64'h200);
        repeat (13) @(posedge fixed_50m_clk);
        #1;
        busy_force = 1'b0;
        for (int k = 0; k < 60 && wlog_addr.size() < 4; k++) @(posedge fixed_50m_clk);
        repeat (6) @(posedge fixed_50m_clk);
        @(negedge fixed_50m_clk);
        check("s3_stored", 64'(wlog_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog_addr.size()) begin
                check($sformatf("s3_order_addr%0d", i), 64'(wlog_addr[i]), 64'h200 + 64'(i));
                check($sformatf("s3_order_data%0d", i), wlog_data[i], {32'hD00D0000, 32'(i)});
            end
        end
        check("s3_busy_clear", 64'(bus.core_busy), 64'd0);

        // Partial write to the cached line, then read it back
        wlog_addr.delete();
        wlog_data.delete();
        r0 = rd_cycles;
        rd_lat = 3;
        do_write(29'h100, 64'hAAAABBBBCCCCDDDD, 8'h03);
        do_read(29'h100, d, lat, ok);
        check("s4_ok", 64'(ok), 64'd1);
        check("s4_data", d, 64'h112233445566DDDD);
        check("s4_ddr_rd_cycles", 64'(rd_cycles - r0), 64'd1);
        check("s4_write_first", 64'(wr_accept_t < rd_accept_t), 64'd1);
        check("s4_writes", 64'(wlog_addr.size()), 64'd1);

        // Reset while waiting on DDR, stray response afterwards
        rd_lat = 12;
        @(posedge fixed_50m_clk); #1;
        bus.core_rd   = 1'b1;
        bus.core_addr = 29'h300;
        repeat (4) @(posedge fixed_50m_clk);
        @(negedge fixed_50m_clk);
        check("s5_in_rd_wait", 64'(dut.state), 64'(RD_WAIT));
        @(posedge fixed_50m_clk); #1;
        reset       = 1'b1;
        bus.core_rd = 1'b0;
        @(posedge fixed_50m_clk); #1;
        reset = 1'b0;
        r0  = n_resp;
        cnt = 0;
        repeat (20) begin
            @(negedge fixed_50m_clk);
            if (bus.core_dout_ready) cnt++;
        end
        check("s5_stray_sent", 64'(n_resp - r0), 64'd1);
        check("s5_no_pulse", 64'(cnt), 64'd0);
        check("s5_idle", 64'(dut.state), 64'(IDLE));
        rd_lat = 2;
        r0 = rd_cycles;
        do_read(29'h100, d, lat, ok);
        check("s5_cache_cleared", 64'(rd_cycles - r0), 64'd1);
        check("s5_data", d, 64'h112233445566DDDD);

        // Random traffic on a small address window
        busy_rand = 1'b1;
        for (int n = 0; n < 80; n++) begin
            logic [28:0] a;
            a = 29'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                do_write(a, {$urandom, $urandom}, 8'($urandom_range(1, 255)));
            end else begin
                rd_lat = $urandom_range(1, 4);
                do_read(a, d, lat, ok);
                check($sformatf("rnd_read_ok_%0d", n), 64'(ok), 64'd1);
                check($sformatf("rnd_read_%0d_a%0d", n, a), d, ref_get(a));
            end
        end
        busy_rand = 1'b0;
        repeat (20) @(posedge fixed_50m_clk);
        @(negedge fixed_50m_clk);
        check("rd_we_exclusive", 64'(excl_viol), 64'd0);
        for (int a = 0; a < 8; a++) check($sformatf("rnd_mem_a%0d", a), ddr_get(29'(a)), ref_get(29'(a)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
